calc_seq: RTL and testbench

Sequencing controller for the calculator datapath: accepts keypad commands, builds two 8-digit BCD operands, runs a digit-serial BCD add/subtract, and drives the 8 BCD digit codes consumed by the seven-segment display bank. It sits between the keypad decoder and the display bank in the top level. It replaces direct per-position digit writes with a calculator entry/compute/show state machine.

---
 rtl/calc_pkg.sv | 26 ++
 rtl/calc_seq_alu.sv | 28 ++
 rtl/calc_seq.sv | 187 ++++++++++++++++++
 tb/tb_calc_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and codes for the calculator sequencing controller.
package calc_pkg;

    localparam int NDIG_DEF = 8;

    localparam logic [3:0] CMD_ADD = 4'd10;
    localparam logic [3:0] CMD_SUB = 4'd11;
    localparam logic [3:0] CMD_EQ  = 4'd12;
    localparam logic [3:0] CMD_CLR = 4'd13;

    localparam logic [3:0] DIG_BLANK = 4'hF;
    localparam logic [3:0] DIG_ERR   = 4'hE;

    typedef enum logic [2:0] {
        ENTRY_A = 3'd0,
        ENTRY_B = 3'd1,
        CALC    = 3'd2,
        SHOW    = 3'd3,
        ERR     = 3'd4
    } state_t;

    function automatic logic is_digit(input logic [3:0] c);
        return c < 4'd10;
    endfunction

endpackage

// File: rtl/calc_seq_alu.sv
// One-digit BCD adder/subtractor; carry-in/out doubles as borrow for sub.
module bcd_digit_alu (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       sub,
    output logic [3:0] r,
    output logic       cout
);

    logic [4:0] sum;
    logic [4:0] diff;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        diff = {1'b0, a} - {1'b0, b} - {4'd0, cin};
        r    = '0;
        cout = 1'b0;
        if (sub) begin
            cout = diff[4];
            r    = diff[4] ? 4'(diff + 5'd10) : diff[3:0];
        end else begin
            cout = sum >= 5'd10;
            r    = (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
        end
    end

endmodule

// File: rtl/calc_seq.sv
// Calculator entry/compute/show sequencer driving the BCD display bank.
module calc_seq
    import calc_pkg::*;
#(
    parameter int NDIG = NDIG_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cmd_valid,
    input  logic [3:0]                 cmd,
    output logic                       cmd_ready,
    output logic [NDIG-1:0][3:0]       data,
    output logic                       busy,
    output logic                       neg,
    output logic                       overflow
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CW = $clog2(NDIG + 1);

    state_t state_q, state_d;
    logic [NDIG-1:0][3:0] a_q, a_d, b_q, b_d, r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic second_q, second_d;
    logic op_q, op_d;
    logic neg_q, neg_d;
    logic c_q, c_d;

    logic       acc;
    logic       room;
    logic [3:0] alu_x, alu_y, alu_r;
    logic       alu_sub, alu_cout;

    // Second pass swaps operands to produce the magnitude B-A.
    assign alu_x   = second_q ? b_q[idx_q] : a_q[idx_q];
    assign alu_y   = second_q ? a_q[idx_q] : b_q[idx_q];
    assign alu_sub = op_q | second_q;

    bcd_digit_alu u_alu (
        .a    (alu_x),
        .b    (alu_y),
        .cin  (c_q),
        .sub  (alu_sub),
        .r    (alu_r),
        .cout (alu_cout)
    );

    assign cmd_ready = state_q != CALC;
    assign acc       = cmd_valid && (cmd_ready || cmd == CMD_CLR);
    assign room      = cnt_q < CW'(NDIG);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        second_d = second_q;
        op_d     = op_q;
        neg_d    = neg_q;
        c_d      = c_q;
        if (acc && cmd == CMD_CLR) begin
            state_d  = ENTRY_A;
            a_d      = '0;
            b_d      = '0;
            r_d      = '0;
            cnt_d    = '0;
            idx_d    = '0;
            second_d = 1'b0;
            op_d     = 1'b0;
            neg_d    = 1'b0;
            c_d      = 1'b0;
        end else begin
            unique case (state_q)
                ENTRY_A: begin
                    if (acc && is_digit(cmd) && room) begin
                        a_d   = {a_q[NDIG-2:0], cmd};
                        cnt_d = cnt_q + 1'b1;
                    end else if (acc && (cmd == CMD_ADD || cmd == CMD_SUB)) begin
                        op_d    = cmd == CMD_SUB;
                        b_d     = '0;
                        cnt_d   = '0;
                        state_d = ENTRY_B;
                    end
                end
                ENTRY_B: begin
                    if (acc && is_digit(cmd) && room) begin
                        b_d   = {b_q[NDIG-2:0], cmd};
                        cnt_d = cnt_q + 1'b1;
                    end else if (acc && (cmd == CMD_ADD || cmd == CMD_SUB)) begin
                        op_d = cmd == CMD_SUB;
                    end else if (acc && cmd == CMD_EQ) begin
                        idx_d    = '0;
                        second_d = 1'b0;
                        c_d      = 1'b0;
                        state_d  = CALC;
                    end
                end
                CALC: begin
                    r_d[idx_q] = alu_r;
                    c_d        = alu_cout;
                    idx_d      = idx_q + 1'b1;
                    if (idx_q == IW'(NDIG - 1)) begin
                        idx_d = '0;
                        c_d   = 1'b0;
                        if (!op_q) begin
                            state_d = alu_cout ? ERR : SHOW;
                        end else if (second_q) begin
                            neg_d   = 1'b1;
                            state_d = SHOW;
                        end else if (alu_cout) begin
                            second_d = 1'b1;
                        end else begin
                            neg_d   = 1'b0;
                            state_d = SHOW;
                        end
                    end
                end
                SHOW: begin
                    if (acc && is_digit(cmd)) begin
                        a_d     = '0;
                        a_d[0]  = cmd;
                        cnt_d   = CW'(1);
                        neg_d   = 1'b0;
                        state_d = ENTRY_A;
                    end else if (acc && !neg_q && (cmd == CMD_ADD || cmd == CMD_SUB)) begin
                        a_d     = r_q;
                        b_d     = '0;
                        cnt_d   = '0;
                        op_d    = cmd == CMD_SUB;
                        state_d = ENTRY_B;
                    end
                end
                ERR: ;
                default: state_d = ENTRY_A;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ENTRY_A;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            second_q <= 1'b0;
            op_q     <= 1'b0;
            neg_q    <= 1'b0;
            c_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            second_q <= second_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            c_q      <= c_d;
        end
    end

    always_comb begin
        data = '0;
        unique case (state_q)
            ENTRY_A: data = a_q;
            ENTRY_B: data = b_q;
            CALC:    data = b_q;
            SHOW:    data = r_q;
            ERR: begin
                for (int i = 0; i < NDIG; i++) data[i] = DIG_BLANK;
                data[0] = DIG_ERR;
            end
            default: data = '0;
        endcase
    end

    assign busy     = state_q == CALC;
    assign overflow = state_q == ERR;
    assign neg      = neg_q;

endmodule

// File: tb/tb_calc_seq.sv
// Directed self-checking bench for calc_seq: vector table plus multi-cycle sequences.
module tb_calc_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [3:0]  cmd;
    logic        cmd_ready;
    logic [7:0][3:0] data;
    logic        busy;
    logic        neg;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;

    calc_seq #(.NDIG(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .data      (data),
        .busy      (busy),
        .neg       (neg),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  c;
        logic [31:0] d;
        logic        n;
        logic        o;
    } vec_t;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_cmd(input logic [3:0] c);
        cmd_valid = 1'b1;
        cmd       = c;
        tick();
        cmd_valid = 1'b0;
        cmd       = 4'd0;
    endtask

    task automatic chk(input string nm, input logic [31:0] ed,
                       input logic eb, input logic en,
                       input logic eo, input logic er);
        n_cmp++;
        if (data !== ed || busy !== eb || neg !== en ||
            overflow !== eo || cmd_ready !== er) begin
            n_bad++;
            $display("FAIL %s: got data=%h busy=%b neg=%b ovf=%b rdy=%b, want data=%h busy=%b neg=%b ovf=%b rdy=%b",
                     nm, data, busy, neg, overflow, cmd_ready,
                     ed, eb, en, eo, er);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, got, exp);
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic enter(input logic [3:0] c);
        do_cmd(c);
    endtask

    initial begin
        vec_t vt[$];
        int   nb;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd       = 4'd0;
        tick();
        tick();
        reset = 1'b0;
        chk("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        vt.push_back('{4'd1,   32'h00000001, 1'b0, 1'b0});
        vt.push_back('{4'd2,   32'h00000012, 1'b0, 1'b0});
        vt.push_back('{4'd3,   32'h00000123, 1'b0, 1'b0});
        vt.push_back('{4'd4,   32'h00001234, 1'b0, 1'b0});
        vt.push_back('{4'd5,   32'h00012345, 1'b0, 1'b0});
        vt.push_back('{4'd6,   32'h00123456, 1'b0, 1'b0});
        vt.push_back('{4'd7,   32'h01234567, 1'b0, 1'b0});
        vt.push_back('{4'd8,   32'h12345678, 1'b0, 1'b0});
        vt.push_back('{4'd9,   32'h12345678, 1'b0, 1'b0});
        vt.push_back('{4'd9,   32'h12345678, 1'b0, 1'b0});
        vt.push_back('{4'd0,   32'h12345678, 1'b0, 1'b0});
        vt.push_back('{4'd9,   32'h12345678, 1'b0, 1'b0});
        vt.push_back('{4'd12,  32'h12345678, 1'b0, 1'b0});
        vt.push_back('{4'd14,  32'h12345678, 1'b0, 1'b0});
        vt.push_back('{4'd15,  32'h12345678, 1'b0, 1'b0});
        vt.push_back('{4'd13,  32'h00000000, 1'b0, 1'b0});
        vt.push_back('{4'd4,   32'h00000004, 1'b0, 1'b0});
        vt.push_back('{4'd11,  32'h00000000, 1'b0, 1'b0});
        vt.push_back('{4'd6,   32'h00000006, 1'b0, 1'b0});
        vt.push_back('{4'd10,  32'h00000006, 1'b0, 1'b0});
        vt.push_back('{4'd13,  32'h00000000, 1'b0, 1'b0});
        for (int i = 0; i < vt.size(); i++) begin
            do_cmd(vt[i].c);
            chk($sformatf("vec%0d", i), vt[i].d, 1'b0, vt[i].n, vt[i].o, 1'b1);
        end

        // 123 + 877 = 1000
        do_cmd(4'd13);
        enter(4'd1); enter(4'd2); enter(4'd3);
        do_cmd(4'd10);
        enter(4'd8); enter(4'd7); enter(4'd7);
        chk("add_b", 32'h00000877, 1'b0, 1'b0, 1'b0, 1'b1);
        do_cmd(4'd12);
        chk("add_busy", 32'h00000877, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_idle(nb);
        chk_int("add_cycles", nb, 8);
        chk("add_res", 32'h00001000, 1'b0, 1'b0, 1'b0, 1'b1);

        // 5 - 12 = -7
        do_cmd(4'd13);
        enter(4'd5);
        do_cmd(4'd11);
        enter(4'd1); enter(4'd2);
        do_cmd(4'd12);
        wait_idle(nb);
        chk_int("sub_cycles", nb, 16);
        chk("sub_res", 32'h00000007, 1'b0, 1'b1, 1'b0, 1'b1);
        do_cmd(4'd10);
        chk("neg_add_ign", 32'h00000007, 1'b0, 1'b1, 1'b0, 1'b1);
        enter(4'd4);
        chk("show_digit", 32'h00000004, 1'b0, 1'b0, 1'b0, 1'b1);

        // 12 - 5 = 7, single pass
        do_cmd(4'd13);
        enter(4'd1); enter(4'd2);
        do_cmd(4'd11);
        enter(4'd5);
        do_cmd(4'd12);
        wait_idle(nb);
        chk_int("subp_cycles", nb, 8);
        chk("subp_res", 32'h00000007, 1'b0, 1'b0, 1'b0, 1'b1);

        // overflow
        do_cmd(4'd13);
        for (int i = 0; i < 8; i++) enter(4'd9);
        do_cmd(4'd10);
        enter(4'd1);
        do_cmd(4'd12);
        wait_idle(nb);
        chk_int("ovf_cycles", nb, 8);
        chk("ovf", 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b1);
        enter(4'd3);
        chk("ovf_dig", 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b1);
        do_cmd(4'd12);
        chk("ovf_eq", 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b1);
        do_cmd(4'd13);
        chk("ovf_clr", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        // EQ dropped mid-CALC
        enter(4'd4);
        do_cmd(4'd10);
        enter(4'd3);
        do_cmd(4'd12);
        tick();
        tick();
        chk("calc_rdy", 32'h00000003, 1'b1, 1'b0, 1'b0, 1'b0);
        do_cmd(4'd12);
        wait_idle(nb);
        chk_int("drop_cycles", nb, 5);
        chk("drop_res", 32'h00000007, 1'b0, 1'b0, 1'b0, 1'b1);

        // CLEAR aborts mid-CALC
        do_cmd(4'd13);
        enter(4'd4);
        do_cmd(4'd10);
        enter(4'd3);
        do_cmd(4'd12);
        tick();
        tick();
        do_cmd(4'd13);
        chk("abort", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        enter(4'd6);
        chk("abort_entry", 32'h00000006, 1'b0, 1'b0, 1'b0, 1'b1);

        // chaining
        do_cmd(4'd13);
        enter(4'd2);
        do_cmd(4'd10);
        enter(4'd3);
        do_cmd(4'd12);
        wait_idle(nb);
        chk("chain1", 32'h00000005, 1'b0, 1'b0, 1'b0, 1'b1);
        do_cmd(4'd10);
        chk("chain_b", 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1);
        enter(4'd4);
        do_cmd(4'd12);
        wait_idle(nb);
        chk("chain2", 32'h00000009, 1'b0, 1'b0, 1'b0, 1'b1);

        // reset beats a same-cycle command
        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd       = 4'd7;
        tick();
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd       = 4'd0;
        chk("rst_prio", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
